btn_event_decoder: RTL and testbench

Consumes the clean, debounced button level produced by the `debounce` block and classifies each gesture into single-cycle event pulses: `click`, `double_click`, `long_press` and auto-`repeat` while held. It sits directly downstream of `debounce` on the same clock and feeds the UI/control logic, which never needs to look at raw button levels.

---
 rtl/btn_event_decoder.sv | 141 ++++++++++++++
 tb/tb_btn_event_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into single-cycle gesture events:
// click, double click, long press and auto-repeat while held.
module btn_event_decoder #(
   parameter int LONG_CYCLES   = 1000,
   parameter int DCLICK_CYCLES = 300,
   parameter int REPEAT_CYCLES = 200,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic click,
   output logic double_click,
   output logic long_press,
   output logic repeat_pulse,
   output logic pressed
);

   // state  | meaning
   // IDLE   | waiting for an armed press
   // PRESS1 | first press held, counting toward long press
   // WAIT2  | released, counting low samples for a possible second press
   // PRESS2 | second press held, double click fires on release
   // LONG   | long press reached, repeating while held
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS1 = 3'd1,
      S_WAIT2  = 3'd2,
      S_PRESS2 = 3'd3,
      S_LONG   = 3'd4
   } state_t;

   // Terminal counts are one below the thresholds: the count is compared
   // before the current sample is added.
   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             armed, armed_nxt;
   logic             click_nxt, double_click_nxt, long_press_nxt, repeat_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         armed        <= 1'b0;
         click        <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         pressed      <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         armed        <= armed_nxt;
         click        <= click_nxt;
         double_click <= double_click_nxt;
         long_press   <= long_press_nxt;
         repeat_pulse <= repeat_nxt;
         pressed      <= btn_in;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      armed_nxt = armed | ~btn_in;
      unique case (state)
         S_IDLE: begin
            if (armed && btn_in) begin
               state_nxt = S_PRESS1;
               cnt_nxt   = CNT_ONE;
            end
         end
         S_PRESS1: begin
            if (btn_in) begin
               if (cnt == LONG_TC) begin
                  state_nxt = S_LONG;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               state_nxt = S_WAIT2;
               cnt_nxt   = CNT_ONE;
            end
         end
         S_WAIT2: begin
            // The window closes on its last sample even if that sample is high.
            if (cnt == DCLICK_TC) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (btn_in) begin
               state_nxt = S_PRESS2;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_PRESS2: begin
            if (!btn_in) begin
               state_nxt = S_IDLE;
            end
         end
         S_LONG: begin
            if (btn_in) begin
               if (cnt == REPEAT_TC) begin
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      click_nxt        = 1'b0;
      double_click_nxt = 1'b0;
      long_press_nxt   = 1'b0;
      repeat_nxt       = 1'b0;
      unique case (state)
         S_PRESS1: long_press_nxt   = btn_in && (cnt == LONG_TC);
         S_WAIT2:  click_nxt        = (cnt == DCLICK_TC);
         S_PRESS2: double_click_nxt = !btn_in;
         S_LONG:   repeat_nxt       = btn_in && (cnt == REPEAT_TC);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomised and directed gesture stimulus for btn_event_decoder, checked by a
// run-length reference model through an expected-event queue.
module tb_btn_event_decoder;

   localparam int L = 20;
   localparam int D = 8;
   localparam int R = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_in = 1'b0;
   logic click, double_click, long_press, repeat_pulse, pressed;

   int total = 0;
   int bad   = 0;

   btn_event_decoder #(
      .LONG_CYCLES  (L),
      .DCLICK_CYCLES(D),
      .REPEAT_CYCLES(R),
      .CNT_W        (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .click       (click),
      .double_click(double_click),
      .long_press  (long_press),
      .repeat_pulse(repeat_pulse),
      .pressed     (pressed)
   );

   always #5 clk = ~clk;

   // codes: 0 none, 1 click, 2 double_click, 3 long_press, 4 repeat, 7 several
   typedef struct {
      int edge_n;
      int code;
   } exp_t;
   exp_t exp_q[$];

   // Reference model in terms of gesture phase and run lengths.
   int   edge_cnt = 0;
   bit   m_armed = 0;
   int   m_phase = 0;   // 0 idle, 1 first hold, 2 release gap, 3 second hold
   int   m_hi = 0;
   int   m_gap = 0;
   logic pressed_exp = 1'b0;

   always @(posedge clk) begin
      int ev;
      edge_cnt++;
      ev = 0;
      if (!rst) begin
         m_armed = 0; m_phase = 0; m_hi = 0; m_gap = 0;
         pressed_exp = 1'b0;
      end else begin
         pressed_exp = btn_in;
         case (m_phase)
            0: if (m_armed && btn_in) begin m_phase = 1; m_hi = 1; end
            1: begin
               if (btn_in) begin
                  m_hi++;
                  if (m_hi == L) ev = 3;
                  else if (m_hi > L && (m_hi - L) % R == 0) ev = 4;
               end else if (m_hi >= L) m_phase = 0;
               else begin m_phase = 2; m_gap = 1; end
            end
            2: begin
               m_gap++;
               if (m_gap == D) begin ev = 1; m_phase = 0; end
               else if (btn_in) m_phase = 3;
            end
            default: if (!btn_in) begin ev = 2; m_phase = 0; end
         endcase
         if (!btn_in) m_armed = 1;
      end
      if (ev != 0) exp_q.push_back('{edge_n: edge_cnt, code: ev});
   end

   // Monitor: compares DUT pulses and registered level after every edge.
   always @(negedge clk) begin
      int dut_code, exp_code;
      case ({click, double_click, long_press, repeat_pulse})
         4'b0000: dut_code = 0;
         4'b1000: dut_code = 1;
         4'b0100: dut_code = 2;
         4'b0010: dut_code = 3;
         4'b0001: dut_code = 4;
         default: dut_code = 7;
      endcase
      exp_code = 0;
      if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
         exp_code = exp_q[0].code;
         void'(exp_q.pop_front());
      end
      if (dut_code != 0 || exp_code != 0) begin
         total++;
         if (dut_code != exp_code) begin
            bad++;
            $display("FAIL event @edge %0d: got code %0d expected %0d", edge_cnt, dut_code, exp_code);
         end
      end
      total++;
      if (pressed !== pressed_exp) begin
         bad++;
         $display("FAIL pressed @edge %0d: got %b expected %b", edge_cnt, pressed, pressed_exp);
      end
   end

   task automatic drive(input logic b, input int n);
      for (int i = 0; i < n; i++) begin
         btn_in = b;
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input logic b, input int n);
      rst = 1'b0;
      drive(b, n);
      rst = 1'b1;
   endtask

   initial begin
      do_reset(1'b0, 3);
      total++;
      if ({click, double_click, long_press, repeat_pulse, pressed} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {click, double_click, long_press, repeat_pulse, pressed});
      end
      drive(1'b0, 2);
      // single click
      drive(1'b1, 3); drive(1'b0, 20);
      // double click
      drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 12);
      // long press with repeats
      drive(1'b1, 32); drive(1'b0, 12);
      // long-press boundary
      drive(1'b1, 19); drive(1'b0, 12);
      drive(1'b1, 20); drive(1'b0, 12);
      drive(1'b1, 21); drive(1'b0, 12);
      // second press landing on the last gap sample
      drive(1'b1, 2); drive(1'b0, D - 1); drive(1'b1, 4); drive(1'b0, 12);
      // second press one sample earlier makes a double click
      drive(1'b1, 2); drive(1'b0, D - 2); drive(1'b1, 30); drive(1'b0, 12);
      // stuck high through reset
      do_reset(1'b1, 2);
      drive(1'b1, 30);
      drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 10);
      // reset mid-gesture at gap count 4
      drive(1'b1, 3); drive(1'b0, 4);
      do_reset(1'b0, 1);
      drive(1'b0, 20);
      // randomised gestures
      for (int g = 0; g < 60; g++) begin
         int hi, lo;
         hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 33)) : int'($urandom_range(1, 6));
         lo = $urandom_range(1, 12);
         drive(1'b1, hi);
         drive(1'b0, lo);
         if ($urandom_range(0, 14) == 0) do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end
      drive(1'b0, 30);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
